and_stage_sched: RTL and testbench

Round-robin scheduler and two-stage pipeline controller that shares a single AND-combine datapath stage between two requesters. Each requester offers an operand pair under a valid/ready handshake. The block arbitrates, registers the winning pair (stage 1), computes and registers the bitwise AND (stage 2), and presents the result with its source ID under a valid/ready handshake to the downstream consumer. It sits between the capture-register stage and the combine/output-register stage of the two-stage datapath.

---
 rtl/and_stage_sched.sv | 113 +++++++++++
 tb/tb_and_stage_sched.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/and_stage_sched.sv
// and_stage_sched: round-robin arbiter feeding a shared two-stage AND pipeline.
// Stage 1 captures the winning operand pair, stage 2 holds the registered AND
// result with its source ID under a valid/ready handshake.
module and_stage_sched #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_src;
  logic             last;

  logic             s2_load;
  logic             s1_load;
  logic             grant0;
  logic             grant1;
  logic             accept0;
  logic             accept1;
  logic             any_accept;
  logic             win_id;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;

  // Pipeline advance conditions, round-robin grant and winner operand mux.
  // Acceptance is masked during reset so nothing is taken while flushing.
  always_comb begin
    s2_load    = !out_valid || out_ready;
    s1_load    = !s1_valid || s2_load;
    grant0     = req0_valid && (!req1_valid || last);
    grant1     = req1_valid && (!req0_valid || !last);
    accept0    = grant0 && s1_load && !rst;
    accept1    = grant1 && s1_load && !rst;
    any_accept = accept0 || accept1;
    win_id     = accept1;
    win_a      = accept1 ? req1_a : req0_a;
    win_b      = accept1 ? req1_b : req0_b;
  end

  assign req0_ready = accept0;
  assign req1_ready = accept1;

  // Stage 2: register the AND of stage 1 whenever the consumer side can move.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      out_data  <= s1_a & s1_b;
      out_src   <= s1_src;
    end
  end

  // Stage 1: capture the winning pair; with no winner only the valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_src   <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= any_accept;
      if (any_accept) begin
        s1_a   <= win_a;
        s1_b   <= win_b;
        s1_src <= win_id;
      end
    end
  end

  // Arbiter pointer and saturating per-requester acceptance counters.
  // The pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last     <= 1'b1;
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (any_accept) begin
        last <= win_id;
      end
      if (accept0 && (gnt_cnt0 != CNT_MAX)) begin
        gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
      end
      if (accept1 && (gnt_cnt1 != CNT_MAX)) begin
        gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_and_stage_sched.sv
// Directed bench for and_stage_sched with WIDTH=4 and CNT_W=2.
module tb_and_stage_sched;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready;
  logic [CNT_W-1:0] gnt_cnt0;
  logic [CNT_W-1:0] gnt_cnt1;

  int compared   = 0;
  int mismatched = 0;

  and_stage_sched #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .gnt_cnt0   (gnt_cnt0),
    .gnt_cnt1   (gnt_cnt1)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 4'hF; req0_b = 4'hF; req1_a = 4'hF; req1_b = 4'hF;
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    compared++; if (req0_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_ready0 got %b want 0", req0_ready); end
    compared++; if (req1_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_ready1 got %b want 0", req1_ready); end
    tick();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_out_valid got %b want 0", out_valid); end
    compared++; if (out_data !== 4'h0) begin mismatched++; $display("[TB] FAIL rst_out_data got %h want 0", out_data); end
    compared++; if (out_src !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_out_src got %b want 0", out_src); end
    compared++; if (gnt_cnt0 !== 2'd0) begin mismatched++; $display("[TB] FAIL rst_cnt0 got %0d want 0", gnt_cnt0); end
    compared++; if (gnt_cnt1 !== 2'd0) begin mismatched++; $display("[TB] FAIL rst_cnt1 got %0d want 0", gnt_cnt1); end
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_out_valid cycle %0d got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_single_stream();
    do_reset();
    req0_valid = 1'b1; req0_a = 4'hF; req0_b = 4'h5;
    @(negedge clk);
    compared++; if (req0_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL ss_ready_first got %b want 1", req0_ready); end
    tick();
    req0_a = 4'h3; req0_b = 4'h6;
    @(negedge clk);
    compared++; if (req0_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL ss_ready_second got %b want 1", req0_ready); end
    tick();
    req0_valid = 1'b0;
    compared++; if ({out_valid, out_src, out_data} !== {1'b1, 1'b0, 4'h5}) begin mismatched++; $display("[TB] FAIL ss_first_result got v=%b s=%b d=%h want v=1 s=0 d=5", out_valid, out_src, out_data); end
    tick();
    compared++; if ({out_valid, out_src, out_data} !== {1'b1, 1'b0, 4'h2}) begin mismatched++; $display("[TB] FAIL ss_second_result got v=%b s=%b d=%h want v=1 s=0 d=2", out_valid, out_src, out_data); end
    compared++; if (gnt_cnt0 !== 2'd2) begin mismatched++; $display("[TB] FAIL ss_cnt0 got %0d want 2", gnt_cnt0); end
    tick();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL ss_drained got %b want 0", out_valid); end
  endtask

  task automatic test_contention();
    logic exp_src;
    logic [WIDTH-1:0] exp_data;
    do_reset();
    req0_valid = 1'b1; req0_a = 4'hC; req0_b = 4'hA;
    req1_valid = 1'b1; req1_a = 4'h7; req1_b = 4'h3;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      compared++; if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin mismatched++; $display("[TB] FAIL ct_grant %0d got r0=%b r1=%b", i, req0_ready, req1_ready); end
      tick();
      if (i >= 1) begin
        exp_src  = ((i - 1) % 2 == 1);
        exp_data = exp_src ? 4'h3 : 4'h8;
        compared++; if ({out_valid, out_src, out_data} !== {1'b1, exp_src, exp_data}) begin mismatched++; $display("[TB] FAIL ct_out %0d got v=%b s=%b d=%h want v=1 s=%b d=%h", i, out_valid, out_src, out_data, exp_src, exp_data); end
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    compared++; if ({out_valid, out_src, out_data} !== {1'b1, 1'b1, 4'h3}) begin mismatched++; $display("[TB] FAIL ct_last_out got v=%b s=%b d=%h want v=1 s=1 d=3", out_valid, out_src, out_data); end
    compared++; if (gnt_cnt0 !== 2'd3) begin mismatched++; $display("[TB] FAIL ct_cnt0 got %0d want 3", gnt_cnt0); end
    compared++; if (gnt_cnt1 !== 2'd3) begin mismatched++; $display("[TB] FAIL ct_cnt1 got %0d want 3", gnt_cnt1); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 4'hF; req0_b = 4'h9;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 4'h6; req1_b = 4'hE;
    @(negedge clk);
    compared++; if (req1_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_fill_ready1 got %b want 1", req1_ready); end
    tick();
    req0_valid = 1'b1; req0_a = 4'h5; req0_b = 4'h5;
    req1_a = 4'hB; req1_b = 4'h3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      compared++; if ({req0_ready, req1_ready} !== 2'b00) begin mismatched++; $display("[TB] FAIL bp_stall_ready %0d got r0=%b r1=%b want 0 0", i, req0_ready, req1_ready); end
      compared++; if ({out_valid, out_src, out_data} !== {1'b1, 1'b0, 4'h9}) begin mismatched++; $display("[TB] FAIL bp_hold %0d got v=%b s=%b d=%h want v=1 s=0 d=9", i, out_valid, out_src, out_data); end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    compared++; if ({req0_ready, req1_ready} !== 2'b10) begin mismatched++; $display("[TB] FAIL bp_release_ready got r0=%b r1=%b want 1 0", req0_ready, req1_ready); end
    tick();
    req0_valid = 1'b0;
    compared++; if ({out_valid, out_src, out_data} !== {1'b1, 1'b1, 4'h6}) begin mismatched++; $display("[TB] FAIL bp_drain1 got v=%b s=%b d=%h want v=1 s=1 d=6", out_valid, out_src, out_data); end
    @(negedge clk);
    compared++; if (req1_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_ready1_late got %b want 1", req1_ready); end
    tick();
    req1_valid = 1'b0;
    compared++; if ({out_valid, out_src, out_data} !== {1'b1, 1'b0, 4'h5}) begin mismatched++; $display("[TB] FAIL bp_drain2 got v=%b s=%b d=%h want v=1 s=0 d=5", out_valid, out_src, out_data); end
    tick();
    compared++; if ({out_valid, out_src, out_data} !== {1'b1, 1'b1, 4'h3}) begin mismatched++; $display("[TB] FAIL bp_drain3 got v=%b s=%b d=%h want v=1 s=1 d=3", out_valid, out_src, out_data); end
    tick();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_empty got %b want 0", out_valid); end
    compared++; if ({gnt_cnt0, gnt_cnt1} !== {2'd2, 2'd2}) begin mismatched++; $display("[TB] FAIL bp_counts got %0d %0d want 2 2", gnt_cnt0, gnt_cnt1); end
  endtask

  task automatic test_saturation();
    logic [CNT_W-1:0] exp_cnt [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    do_reset();
    req1_valid = 1'b1; req1_a = 4'h1; req1_b = 4'h1;
    for (int i = 0; i < 6; i++) begin
      tick();
      compared++; if (gnt_cnt1 !== exp_cnt[i]) begin mismatched++; $display("[TB] FAIL sat_cnt1 %0d got %0d want %0d", i, gnt_cnt1, exp_cnt[i]); end
    end
    req1_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_midstream_reset();
    do_reset();
    out_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 4'hF; req0_b = 4'hF;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 4'hF; req1_b = 4'hA;
    tick();
    rst = 1'b1;
    @(negedge clk);
    compared++; if ({req0_ready, req1_ready} !== 2'b00) begin mismatched++; $display("[TB] FAIL mr_ready_in_rst got r0=%b r1=%b want 0 0", req0_ready, req1_ready); end
    tick();
    rst = 1'b0;
    req1_valid = 1'b0;
    compared++; if ({out_valid, out_data} !== {1'b0, 4'h0}) begin mismatched++; $display("[TB] FAIL mr_flushed got v=%b d=%h want v=0 d=0", out_valid, out_data); end
    compared++; if ({gnt_cnt0, gnt_cnt1} !== {2'd0, 2'd0}) begin mismatched++; $display("[TB] FAIL mr_counts got %0d %0d want 0 0", gnt_cnt0, gnt_cnt1); end
    out_ready = 1'b1;
    tick();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mr_no_stale got %b want 0", out_valid); end
    req0_valid = 1'b1; req0_a = 4'h9; req0_b = 4'hC;
    req1_valid = 1'b1; req1_a = 4'h7; req1_b = 4'h7;
    @(negedge clk);
    compared++; if ({req0_ready, req1_ready} !== 2'b10) begin mismatched++; $display("[TB] FAIL mr_first_tie got r0=%b r1=%b want 1 0", req0_ready, req1_ready); end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    compared++; if ({out_valid, out_src, out_data} !== {1'b1, 1'b0, 4'h8}) begin mismatched++; $display("[TB] FAIL mr_result got v=%b s=%b d=%h want v=1 s=0 d=8", out_valid, out_src, out_data); end
    compared++; if (gnt_cnt0 !== 2'd1) begin mismatched++; $display("[TB] FAIL mr_cnt0 got %0d want 1", gnt_cnt0); end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    test_reset();
    test_single_stream();
    test_contention();
    test_backpressure();
    test_saturation();
    test_midstream_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
